clk_div_ctrl: RTL and testbench
===============================

Name: clk_div_ctrl

Overview:
- Arbitrated configuration controller for the clock divider's DIVISOR input.
- Multiple requesters (UART baud, display refresh, debug stepping) each request a new divisor. The block grants one at a time, round-robin.
- It applies the new value only at the divider's wrap point, so a smaller divisor never lets CLK_COUNT run past it and wrap through 2^WIDTH.
- It sits between the requesters and the divider, and owns the divider's DIVISOR net.

Parameters:
N_REQ, 4, number of requesters (2..8)
WIDTH, 32, divisor/count width; matches the divider
RESET_DIVISOR, 1, DIVISOR value driven out of reset

Ports:
CLK_IN  in  1  system clock; same clock as the divider
RST  in  1  reset, asynchronous, active-high
REQ_VALID  in  N_REQ  per-requester request; held high until its REQ_ACK
REQ_DIVISOR  in  N_REQ*WIDTH  requested divisor; slice i = bits [i*WIDTH +: WIDTH]
REQ_ACK  out  N_REQ  one-cycle pulse: request i has been applied
CLK_COUNT  in  WIDTH  divider's current count
DIVISOR  out  WIDTH  registered divisor driven to the divider
BUSY  out  1  high whenever state != IDLE
GRANT_ID  out  3  index of current or last grantee
UPDATE_CNT  out  16  number of completed requests; wraps at 2^16

Behaviour:
- Reset (async, RST=1) values:
  - DIVISOR=RESET_DIVISOR, REQ_ACK=0, BUSY=0, GRANT_ID=0, UPDATE_CNT=0.
  - State IDLE; round-robin pointer selects requester 0 first.
  - Any latched pending request is discarded; no ACK is issued for it.
- Internal registers: PEND_DIV (WIDTH), PEND_ID, RR_PTR, state.
- State IDLE:
  - If any REQ_VALID is set, grant the first set bit at or after RR_PTR, wrapping modulo N_REQ.
  - Latch PEND_DIV = REQ_DIVISOR[grant] and PEND_ID = grant; GRANT_ID = grant.
  - If PEND_DIV value equals the current DIVISOR, go to ACK; otherwise go to WAIT_WRAP.
- State WAIT_WRAP:
  - Boundary condition: CLK_COUNT >= DIVISOR. Unsigned compare; ">=" also recovers a count that is already past DIVISOR.
  - In a boundary cycle, register DIVISOR <= PEND_DIV and go to ACK.
  - This is the same edge at which the divider clears its count, so the new divisor is first compared against count 0.
  - Otherwise remain in WAIT_WRAP. There is no timeout; the wait is at most old DIVISOR+1 cycles.
- State ACK:
  - REQ_ACK[PEND_ID]=1 for exactly this cycle.
  - UPDATE_CNT increments; RR_PTR = PEND_ID+1 modulo N_REQ; next state is IDLE.
- Latency, VALID first sampled in IDLE at cycle t:
  - Equal divisor: ACK at t+1.
  - Otherwise: DIVISOR changes at the edge ending boundary cycle b (b >= t+1), and ACK is at b+1.
  - Back-to-back throughput: one request per 2 cycles minimum.
- Requester rules:
  - A requester must drop REQ_VALID in the cycle after its ACK.
  - If REQ_VALID is still high in IDLE, it is a new request. The rotated pointer still gives others priority.
  - REQ_DIVISOR is sampled only at grant. Later changes, or dropping REQ_VALID before ACK, do not cancel the request; it completes and ACKs.
- Simultaneous requests: strict round-robin. After requester k is served, k has the lowest priority.
- Divisor 0 is legal and is passed through unchanged.
- Exactly one REQ_ACK bit is high at a time, and only in ACK.

Decomposition:
- Shared package/header clk_div_pkg holds:
  - state encodings IDLE=0, WAIT_WRAP=1, ACK=2;
  - default WIDTH=32;
  - RESET_DIVISOR default.
- Sub-module rr_arbiter (N_REQ parameter):
  - inputs REQ and PTR; outputs one-hot GRANT, GRANT_IDX and ANY.
  - Purely combinational priority rotate; reused by other shared-resource blocks.

Test Plan:
1. Reset and hold: RST pulsed mid-WAIT_WRAP with a request pending -> DIVISOR=1, BUSY=0, no REQ_ACK ever issued, UPDATE_CNT=0.
2. Shrink safely:
   - Setup: DIVISOR=100, divider count at 60, REQ_VALID[0] with divisor 10.
   - DIVISOR must stay 100 until the cycle CLK_COUNT=100, then change to 10; ACK[0] one cycle later.
   - Divider count never exceeds 100.
3. Equal value: DIVISOR=1, request 1 with divisor 1 -> ACK[1] exactly 1 cycle after grant, DIVISOR unchanged, UPDATE_CNT=1.
4. Fairness:
   - Stimulus: all 4 REQ_VALID held with distinct divisors 2, 3, 4, 5, each requester re-asserting after its ACK.
   - Required: ACK order 0, 1, 2, 3, 0, 1 ...; GRANT_ID follows the same order; exactly one ACK bit high per ACK cycle.
5. Out-of-sync recovery: force CLK_COUNT=500 with DIVISOR=20, request divisor 50 -> applied in the first WAIT_WRAP cycle (500>=20), ACK next cycle.
6. Withdrawn request: REQ_VALID[2] dropped 1 cycle after grant -> request still applied at the boundary, ACK[2] pulses, UPDATE_CNT increments.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the divider configuration controller.
package clk_div_pkg;

    // Controller phases: idle, waiting for the divider wrap, acknowledging.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_WRAP = 2'd1,
        ACK       = 2'd2
    } state_t;

    localparam int DEF_WIDTH         = 32;
    localparam int DEF_RESET_DIVISOR = 1;

    // Requester index width; covers up to 8 requesters.
    localparam int ID_W = 3;

    // Next requester index after id, wrapping modulo n.
    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] id, input int n);
        if (int'(id) >= n - 1) return '0;
        return id + 1'b1;
    endfunction

endpackage

// File: rtl/clk_div_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after PTR,
// wrapping modulo N_REQ. Shared by other shared-resource blocks.
module rr_arbiter
    import clk_div_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] REQ,
    input  logic [ID_W-1:0]  PTR,
    output logic [N_REQ-1:0] GRANT,
    output logic [ID_W-1:0]  GRANT_IDX,
    output logic             ANY
);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    int                 sel;

    // Rotate requests so PTR lands at bit 0, then pick the lowest set bit.
    always_comb begin
        dbl       = {REQ, REQ} >> PTR;
        rot       = dbl[N_REQ-1:0];
        ANY       = 1'b0;
        sel       = 0;
        GRANT_IDX = '0;
        GRANT     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!ANY && rot[i]) begin
                ANY = 1'b1;
                sel = int'(PTR) + i;
                if (sel >= N_REQ) sel = sel - N_REQ;
            end
        end
        if (ANY) GRANT_IDX = ID_W'(sel);
        for (int j = 0; j < N_REQ; j++) begin
            GRANT[j] = ANY && (GRANT_IDX == ID_W'(j));
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Arbitrated DIVISOR controller: grants one requester at a time round-robin
// and swaps the divisor only at the divider's wrap point, so a shrinking
// divisor never strands the count above it.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int WIDTH         = DEF_WIDTH,
    parameter int RESET_DIVISOR = DEF_RESET_DIVISOR
) (
    input  logic                   CLK_IN,
    input  logic                   RST,
    input  logic [N_REQ-1:0]       REQ_VALID,
    input  logic [N_REQ*WIDTH-1:0] REQ_DIVISOR,
    output logic [N_REQ-1:0]       REQ_ACK,
    input  logic [WIDTH-1:0]       CLK_COUNT,
    output logic [WIDTH-1:0]       DIVISOR,
    output logic                   BUSY,
    output logic [2:0]             GRANT_ID,
    output logic [15:0]            UPDATE_CNT
);

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  pend_div;
    logic [ID_W-1:0]   pend_id;
    logic [ID_W-1:0]   rr_ptr;
    logic [N_REQ-1:0]  grant;
    logic [ID_W-1:0]   grant_idx;
    logic              any_req;
    logic [WIDTH-1:0]  grant_div;
    logic              boundary;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .REQ       (REQ_VALID),
        .PTR       (rr_ptr),
        .GRANT     (grant),
        .GRANT_IDX (grant_idx),
        .ANY       (any_req)
    );

    // Divisor slice of the granted requester.
    always_comb begin
        grant_div = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) grant_div = REQ_DIVISOR[i*WIDTH +: WIDTH];
        end
    end

    // ">=" rather than "==" also recovers a count already past DIVISOR.
    assign boundary = (CLK_COUNT >= DIVISOR);

    // State register.
    always_ff @(posedge CLK_IN or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state: equal divisors skip the wrap wait entirely.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (any_req) state_nxt = (grant_div == DIVISOR) ? ACK : WAIT_WRAP;
            WAIT_WRAP: if (boundary) state_nxt = ACK;
            ACK:       state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Grant latch, wrap-aligned divisor update, completion bookkeeping.
    always_ff @(posedge CLK_IN or posedge RST) begin
        if (RST) begin
            DIVISOR    <= WIDTH'(RESET_DIVISOR);
            pend_div   <= '0;
            pend_id    <= '0;
            rr_ptr     <= '0;
            GRANT_ID   <= '0;
            UPDATE_CNT <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        pend_div <= grant_div;
                        pend_id  <= grant_idx;
                        GRANT_ID <= grant_idx;
                    end
                end
                WAIT_WRAP: begin
                    // Same edge at which the divider clears its count.
                    if (boundary) DIVISOR <= pend_div;
                end
                ACK: begin
                    UPDATE_CNT <= UPDATE_CNT + 16'd1;
                    rr_ptr     <= wrap_inc(pend_id, N_REQ);
                end
                default: ;
            endcase
        end
    end

    // One-hot acknowledge for the pending requester, only while in ACK.
    always_comb begin
        REQ_ACK = '0;
        for (int i = 0; i < N_REQ; i++) begin
            REQ_ACK[i] = (state == ACK) && (pend_id == ID_W'(i));
        end
    end

    assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: directed scenarios plus random traffic, all
// checked each cycle against a transaction-level model of the controller.
module tb_clk_div_ctrl;

    localparam int N = 4;
    localparam int W = 32;

    logic           CLK_IN = 1'b0;
    logic           RST;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_div;
    logic [N-1:0]   req_ack;
    logic [W-1:0]   clk_count;
    logic [W-1:0]   divisor;
    logic           busy;
    logic [2:0]     grant_id;
    logic [15:0]    update_cnt;

    // Divider stand-in with load and override hooks.
    logic [W-1:0]   div_cnt = '0;
    logic           load_cnt;
    logic [W-1:0]   load_val;
    logic           ovr_en;
    logic [W-1:0]   ovr_val;

    int total = 0;
    int bad   = 0;

    // Model: one outstanding transaction, "done" once its divisor is live.
    bit          m_open, m_done;
    int          m_pid, m_gid, m_ptr, m_cnt;
    logic [W-1:0] m_div, m_pdiv;

    clk_div_ctrl #(.N_REQ(N), .WIDTH(W), .RESET_DIVISOR(1)) dut (
        .CLK_IN      (CLK_IN),
        .RST         (RST),
        .REQ_VALID   (req_valid),
        .REQ_DIVISOR (req_div),
        .REQ_ACK     (req_ack),
        .CLK_COUNT   (clk_count),
        .DIVISOR     (divisor),
        .BUSY        (busy),
        .GRANT_ID    (grant_id),
        .UPDATE_CNT  (update_cnt)
    );

    always #5 CLK_IN = ~CLK_IN;

    assign clk_count = ovr_en ? ovr_val : div_cnt;

    always @(posedge CLK_IN) begin
        if (load_cnt)              div_cnt <= load_val;
        else if (div_cnt >= divisor) div_cnt <= '0;
        else                       div_cnt <= div_cnt + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) t=%0t", nm, act, act, exp, exp, $time);
        end
    endtask

    task automatic set_div(input int i, input logic [W-1:0] v);
        req_div[i*W +: W] = v;
    endtask

    function automatic int idx_of(input logic [N-1:0] v);
        idx_of = -1;
        for (int i = 0; i < N; i++) if (v[i]) idx_of = i;
    endfunction

    // Compare DUT against the model, then advance the model by one cycle.
    task automatic model_cycle();
        logic [N-1:0] exp_ack;
        bit           found;
        int           i;
        if (RST) begin
            m_open = 0; m_done = 0; m_pid = 0; m_gid = 0;
            m_ptr = 0; m_cnt = 0; m_div = 1; m_pdiv = '0;
        end
        exp_ack = (m_open && m_done) ? N'(1 << m_pid) : '0;
        chk("m_divisor",    divisor,          m_div);
        chk("m_busy",       32'(busy),        32'(m_open));
        chk("m_grant_id",   32'(grant_id),    32'(m_gid));
        chk("m_update_cnt", 32'(update_cnt),  32'(m_cnt));
        chk("m_req_ack",    32'(req_ack),     32'(exp_ack));
        if (!RST) begin
            if (!m_open) begin
                found = 0;
                for (int off = 0; off < N; off++) begin
                    i = (m_ptr + off) % N;
                    if (!found && req_valid[i]) begin
                        found  = 1;
                        m_open = 1;
                        m_pid  = i;
                        m_gid  = i;
                        m_pdiv = req_div[i*W +: W];
                        m_done = (m_pdiv == m_div);
                    end
                end
            end else if (!m_done) begin
                if (clk_count >= m_div) begin
                    m_div  = m_pdiv;
                    m_done = 1;
                end
            end else begin
                m_open = 0;
                m_done = 0;
                m_cnt  = (m_cnt + 1) % 65536;
                m_ptr  = (m_pid + 1) % N;
            end
        end
    endtask

    // Advance one cycle; returns 1 time unit after the rising edge.
    task automatic tick();
        @(negedge CLK_IN);
        model_cycle();
        @(posedge CLK_IN);
        #1;
    endtask

    task automatic wait_ack(input int i, input int maxc);
        bit ok;
        ok = 0;
        for (int k = 0; k < maxc; k++) begin
            if (req_ack[i]) begin ok = 1; break; end
            tick();
        end
        chk($sformatf("ack%0d_seen", i), 32'(ok), 32'd1);
    endtask

    initial begin
        int maxc, acks, nack;
        bit seen;

        RST = 1; req_valid = '0; req_div = '0;
        load_cnt = 0; load_val = '0; ovr_en = 0; ovr_val = '0;
        tick(); tick();
        RST = 0;
        chk("rst_div",  divisor, 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_gid",  32'(grant_id), 32'd0);
        chk("rst_upd",  32'(update_cnt), 32'd0);
        chk("rst_ack",  32'(req_ack), 32'd0);

        // Equal divisor: ACK one cycle after grant.
        set_div(1, 1); req_valid[1] = 1;
        tick();
        chk("eq_ack", 32'(req_ack), 32'b0010);
        chk("eq_gid", 32'(grant_id), 32'd1);
        chk("eq_div", divisor, 32'd1);
        req_valid[1] = 0;
        tick();
        chk("eq_upd",  32'(update_cnt), 32'd1);
        chk("eq_busy", 32'(busy), 32'd0);

        // Shrink 100 -> 10 from count 60.
        set_div(0, 100); req_valid[0] = 1;
        wait_ack(0, 10);
        req_valid[0] = 0;
        chk("grow_div", divisor, 32'd100);
        load_val = 60; load_cnt = 1;
        tick();
        load_cnt = 0;
        chk("shrink_start", clk_count, 32'd60);
        set_div(0, 10); req_valid[0] = 1;
        maxc = 0; seen = 0;
        for (int k = 0; k < 80; k++) begin
            tick();
            if (int'(clk_count) > maxc) maxc = int'(clk_count);
            if (clk_count == 100) begin seen = 1; break; end
        end
        chk("shrink_seen",  32'(seen), 32'd1);
        chk("shrink_hold",  divisor, 32'd100);
        chk("shrink_noack", 32'(req_ack), 32'd0);
        tick();
        chk("shrink_new",  divisor, 32'd10);
        chk("shrink_ack",  32'(req_ack), 32'b0001);
        chk("shrink_wrap", clk_count, 32'd0);
        chk("shrink_max",  32'(maxc), 32'd100);
        req_valid[0] = 0;
        tick();

        // Out-of-sync count recovers in the first wait cycle.
        set_div(0, 20); req_valid[0] = 1;
        wait_ack(0, 40);
        req_valid[0] = 0;
        tick();
        chk("oos_pre_div", divisor, 32'd20);
        ovr_en = 1; ovr_val = 500;
        set_div(3, 50); req_valid[3] = 1;
        tick();
        chk("oos_busy", 32'(busy), 32'd1);
        chk("oos_gid",  32'(grant_id), 32'd3);
        chk("oos_hold", divisor, 32'd20);
        tick();
        chk("oos_div", divisor, 32'd50);
        chk("oos_ack", 32'(req_ack), 32'b1000);
        req_valid[3] = 0; ovr_en = 0;
        tick();

        // Withdrawn request still completes with the sampled divisor.
        set_div(2, 7); req_valid[2] = 1;
        tick();
        chk("wd_gid",  32'(grant_id), 32'd2);
        chk("wd_busy", 32'(busy), 32'd1);
        req_valid[2] = 0; set_div(2, 9);
        wait_ack(2, 60);
        chk("wd_ack", 32'(req_ack), 32'b0100);
        chk("wd_div", divisor, 32'd7);
        tick();
        chk("wd_upd", 32'(update_cnt), 32'd6);

        // Reset while waiting for a wrap that never comes.
        ovr_en = 1; ovr_val = 0;
        set_div(1, 30); req_valid[1] = 1;
        tick(); tick();
        chk("rw_busy", 32'(busy), 32'd1);
        chk("rw_div",  divisor, 32'd7);
        RST = 1; req_valid[1] = 0;
        #1;
        chk("rw_rst_div",  divisor, 32'd1);
        chk("rw_rst_busy", 32'(busy), 32'd0);
        chk("rw_rst_upd",  32'(update_cnt), 32'd0);
        tick();
        RST = 0; ovr_en = 0;
        acks = 0;
        for (int k = 0; k < 20; k++) begin
            if (req_ack != '0) acks++;
            tick();
        end
        chk("rw_noack", 32'(acks), 32'd0);
        chk("rw_upd",   32'(update_cnt), 32'd0);
        chk("rw_div2",  divisor, 32'd1);

        // Fairness: all requesters held, strict rotation.
        for (int i = 0; i < N; i++) set_div(i, 32'(i + 2));
        req_valid = '1;
        nack = 0;
        for (int k = 0; k < 200 && nack < 8; k++) begin
            if (req_ack != '0) begin
                chk("fair_onehot", 32'($onehot(req_ack)), 32'd1);
                chk("fair_order",  32'(idx_of(req_ack)), 32'(nack % N));
                chk("fair_gid",    32'(grant_id), 32'(nack % N));
                nack++;
            end
            tick();
        end
        chk("fair_count", 32'(nack), 32'd8);
        req_valid = '0;
        tick(); tick();

        // Random traffic, occasional count overrides and resets.
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(3) == 0) req_valid[i] = ~req_valid[i];
                if ($urandom_range(3) == 0) set_div(i, W'($urandom_range(12)));
            end
            if ($urandom_range(15) == 0) begin
                ovr_en  = ~ovr_en;
                ovr_val = W'($urandom_range(30));
            end
            if (RST) RST = 0;
            else if ($urandom_range(499) == 0) RST = 1;
            tick();
        end
        RST = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
